// File: rtl/debounce_filter.sv
// debounce_filter
//   Debounces a raw, asynchronous, bouncing push-button input. The input is first brought into
//   the clock domain by a 2-flop synchronizer. A four-state Moore FSM then requires
//   STABLE_CYCLES consecutive agreeing samples before it changes the clean output level.
//   Each qualification that is abandoned part-way counts as a rejected glitch.
//
// Parameters
//   STABLE_CYCLES  consecutive agreeing samples needed to change level (2..255)
//   CNT_W          stability counter width; must be able to hold STABLE_CYCLES-1
//
// Ports
//   clock       in   system clock; all state updates on its rising edge
//   reset       in   synchronous, active-high reset
//   button      in   raw, asynchronous, bouncing input
//   level       out  debounced level (registered)
//   busy        out  high while a level change is being qualified (registered)
//   glitch_cnt  out  saturating count of rejected transitions
module debounce_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    output logic       level,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        StLow      = 2'd0,
        StWaitHigh = 2'd1,
        StHigh     = 2'd2,
        StWaitLow  = 2'd3
    } state_e;

    // Final count value; reaching it while the input still agrees commits the new level.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             button_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             glitch_inc;

    assign button_s = sync2_q;

    always_comb begin
        sync1_d    = button;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_inc = 1'b0;

        case (state_q)
            StLow: begin
                if (button_s) begin
                    state_d = StWaitHigh;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWaitHigh: begin
                if (button_s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = StLow;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end
            end
            StHigh: begin
                if (!button_s) begin
                    state_d = StWaitLow;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWaitLow: begin
                if (!button_s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = StHigh;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase

        // Saturate rather than wrap so a long bouncy period never reads back as "few glitches".
        glitch_d = (glitch_inc && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;

        // Outputs are decoded from the next state and registered, so they track state_q exactly
        // while coming straight off flops.
        level_d = (state_d == StHigh) || (state_d == StWaitLow);
        busy_d  = (state_d == StWaitHigh) || (state_d == StWaitLow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= StLow;
            cnt_q    <= '0;
            glitch_q <= 8'd0;
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
        end
    end

    assign level      = level_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter
//   Directed bench for debounce_filter. Instance dut_a uses the default STABLE_CYCLES=4,
//   instance dut_b uses STABLE_CYCLES=2. A table of per-edge records {instance, button, reset,
//   expected level/busy/glitch_cnt} is applied one clock edge per record; saturation of the
//   glitch counter is exercised by a hand-written loop.
module tb_debounce_filter;

    logic       clock = 1'b0;
    logic       reset_a = 1'b1, button_a = 1'b0;
    logic       reset_b = 1'b1, button_b = 1'b0;
    logic       level_a, busy_a, level_b, busy_b;
    logic [7:0] glitch_a, glitch_b;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit       sel;
        bit       btn;
        bit       rst;
        bit       lvl;
        bit       bsy;
        bit [7:0] glc;
    } vec_t;

    vec_t vecs[$];

    debounce_filter #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut_a (
        .clock     (clock),
        .reset     (reset_a),
        .button    (button_a),
        .level     (level_a),
        .busy      (busy_a),
        .glitch_cnt(glitch_a)
    );

    debounce_filter #(
        .STABLE_CYCLES(2),
        .CNT_W        (8)
    ) dut_b (
        .clock     (clock),
        .reset     (reset_b),
        .button    (button_b),
        .level     (level_b),
        .busy      (busy_b),
        .glitch_cnt(glitch_b)
    );

    always #5 clock = ~clock;

    task automatic v(input bit sel, input bit btn, input bit rst,
                     input bit lvl, input bit bsy, input int glc);
        vec_t r;
        r.sel = sel;
        r.btn = btn;
        r.rst = rst;
        r.lvl = lvl;
        r.bsy = bsy;
        r.glc = 8'(glc);
        vecs.push_back(r);
    endtask

    // Drive one instance's inputs away from the edge, then sample just after the edge.
    task automatic step(input bit sel, input bit btn, input bit rst);
        @(negedge clock);
        if (sel) begin
            button_b = btn;
            reset_b  = rst;
        end else begin
            button_a = btn;
            reset_a  = rst;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input bit sel,
                         input bit lvl, input bit bsy, input bit [7:0] glc);
        logic       al, ab;
        logic [7:0] ag;
        al = sel ? level_b  : level_a;
        ab = sel ? busy_b   : busy_a;
        ag = sel ? glitch_b : glitch_a;
        n_vec++;
        if ({al, ab, ag} !== {lvl, bsy, glc}) begin
            n_bad++;
            $display("FAIL %s: got level=%b busy=%b glitch_cnt=%0d, expected level=%b busy=%b glitch_cnt=%0d",
                     name, al, ab, ag, lvl, bsy, glc);
        end
    endtask

    initial begin
        // ---------------- instance A, STABLE_CYCLES=4 ----------------
        v(0, 0, 1, 0, 0, 0);                           // reset
        // button=1 before edge 1: busy after edges 3-5, level from edge 6
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 1, 0);
        v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 1, 0, 0);
        v(0, 1, 0, 1, 0, 0);
        // falling edge captured at edge 8, level falls at edge 13
        v(0, 0, 0, 1, 0, 0); v(0, 0, 0, 1, 0, 0); v(0, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0); v(0, 0, 0, 1, 1, 0); v(0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // 2-clock high pulse from LOW: busy pulses, rejected
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 0); v(0, 0, 0, 0, 1, 0); v(0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1);
        // rise to HIGH again
        v(0, 1, 0, 0, 0, 1); v(0, 1, 0, 0, 0, 1); v(0, 1, 0, 0, 1, 1);
        v(0, 1, 0, 0, 1, 1); v(0, 1, 0, 0, 1, 1); v(0, 1, 0, 1, 0, 1);
        v(0, 1, 0, 1, 0, 1);
        // bounce 0-1-0-1 then settle low at edge 32: two aborts, level falls at edge 37
        v(0, 0, 0, 1, 0, 1); v(0, 1, 0, 1, 0, 1); v(0, 0, 0, 1, 1, 1);
        v(0, 1, 0, 1, 0, 2); v(0, 0, 0, 1, 1, 2); v(0, 0, 0, 1, 0, 3);
        v(0, 0, 0, 1, 1, 3); v(0, 0, 0, 1, 1, 3); v(0, 0, 0, 1, 1, 3);
        v(0, 0, 0, 0, 0, 3); v(0, 0, 0, 0, 0, 3);
        // enter WAIT_HIGH, reset when cnt=2, button held through release
        v(0, 1, 0, 0, 0, 3); v(0, 1, 0, 0, 0, 3); v(0, 1, 0, 0, 1, 3);
        v(0, 1, 0, 0, 1, 3);
        v(0, 1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 1, 0);
        v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 1, 0, 0);
        v(0, 1, 0, 1, 0, 0);

        // ---------------- instance B, STABLE_CYCLES=2 ----------------
        v(1, 0, 1, 0, 0, 0);
        // rise captured at edge 1, level at edge 4
        v(1, 1, 0, 0, 0, 0); v(1, 1, 0, 0, 0, 0); v(1, 1, 0, 0, 1, 0);
        v(1, 1, 0, 1, 0, 0);
        // fall captured at edge 5, level at edge 8
        v(1, 0, 0, 1, 0, 0); v(1, 0, 0, 1, 0, 0); v(1, 0, 0, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0);
        // 1-clock pulse rejected
        v(1, 1, 0, 0, 0, 0); v(1, 0, 0, 0, 0, 0); v(1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 0, 1); v(1, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].sel, vecs[i].btn, vecs[i].rst);
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].lvl, vecs[i].bsy, vecs[i].glc);
        end

        // ---------------- glitch_cnt saturation on instance A ----------------
        step(0, 0, 1);
        check("sat_reset", 0, 1'b0, 1'b0, 8'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0);
            step(0, 1, 0);
            step(0, 0, 0);
            step(0, 0, 0);
            // Pulse i is still mid-qualification here; pulses 0..i-1 have been rejected.
            check($sformatf("sat_pulse%0d", i), 0, 1'b0, 1'b1, 8'((i > 255) ? 255 : i));
        end
        step(0, 0, 0);
        step(0, 0, 0);
        check("sat_final", 0, 1'b0, 1'b0, 8'd255);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            step(0, 1, 0);
            step(0, 0, 0);
            step(0, 0, 0);
            step(0, 0, 0);
        end
        check("sat_hold", 0, 1'b0, 1'b0, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive agreeing samples needed to change the level (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the internal stability counter; it SHALL hold STABLE_CYCLES-1.
REQ-003 The block SHALL have port clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port button  input  1  raw, asynchronous, bouncing input.
REQ-006 The block SHALL have port level  output  1  debounced clean level, intended to drive the downstream edge-detector's level input.
REQ-007 The block SHALL have port busy  output  1  high while a level change is being qualified.
REQ-008 The block SHALL have port glitch_cnt  output  8  saturating count of rejected transitions.

Function
REQ-009 button SHALL pass through a 2-flop synchronizer; the second flop output (button_s) SHALL be the only version of button used by the FSM.
REQ-010 The FSM SHALL have four registered states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-011 level SHALL be 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH; busy SHALL be 1 only in WAIT_HIGH and WAIT_LOW; both SHALL be decoded from registered state only (Moore, glitch-free).
REQ-012 In LOW with button_s=1, the FSM SHALL go to WAIT_HIGH and load cnt=1; in LOW with button_s=0 it SHALL stay in LOW.
REQ-013 In HIGH with button_s=0, the FSM SHALL go to WAIT_LOW and load cnt=1; in HIGH with button_s=1 it SHALL stay in HIGH.
REQ-014 In WAIT_HIGH with button_s=1, the FSM SHALL go to HIGH if cnt==STABLE_CYCLES-1, else increment cnt.
REQ-015 In WAIT_LOW with button_s=0, the FSM SHALL go to LOW if cnt==STABLE_CYCLES-1, else increment cnt.
REQ-016 In WAIT_HIGH with button_s=0, the FSM SHALL return to LOW, clear cnt, and increment glitch_cnt.
REQ-017 In WAIT_LOW with button_s=1, the FSM SHALL return to HIGH, clear cnt, and increment glitch_cnt.
REQ-018 glitch_cnt SHALL saturate at 255 and never wrap.
REQ-019 Latency: for a raw change captured by the first sync flop at edge k and held stable, level SHALL update at edge k+STABLE_CYCLES+1 (edge k+5 at default).
REQ-020 Any excursion of button_s shorter than STABLE_CYCLES samples SHALL NOT change level.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1; cnt SHALL be don't-care outside the WAIT states but SHALL be cleared on every WAIT exit.
REQ-022 Unused state encodings SHALL transition to LOW on the next edge.

Reset
REQ-023 While reset=1 at a rising edge, both sync flops, cnt and glitch_cnt SHALL clear to 0, state SHALL become LOW, and level and busy SHALL be 0; reset SHALL take priority over all other events.
REQ-024 Reset asserted during WAIT_HIGH or WAIT_LOW SHALL abort qualification with no glitch_cnt increment.
REQ-025 If button is held at 1 through reset release, level SHALL rise per REQ-019, counting from the first post-reset edge.

Verification
REQ-026 Reset, then button=1 set before edge 1: busy=1 after edges 3-5; level=1 and busy=0 from edge 6; glitch_cnt=0.
REQ-027 From LOW, button=1 for 2 clocks then 0: level stays 0 throughout; busy pulses; glitch_cnt=1.
REQ-028 From HIGH, button=0 held: level=0 at edge k+5; bounce 1-0-1-0 of 1-clock pulses before settling low: level falls 5 edges after the final settle; glitch_cnt incremented once per aborted qualification.
REQ-029 300 aborted 2-clock pulses: glitch_cnt reads 255 and holds.
REQ-030 Reset asserted for 1 cycle while in WAIT_HIGH with cnt=2: next edge state=LOW, level=0, busy=0, glitch_cnt=0.
REQ-031 STABLE_CYCLES=2: stable rise captured at edge k gives level=1 at edge k+3; a 1-clock pulse is rejected.
